circle_scheduler: RTL and testbench

//  Command-queue front end for the circle engine. Buffers draw commands (screen clear or circle),

---
 rtl/circle_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_circle_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_scheduler.sv
// Command-queue front end for the circle engine: buffers clear/circle commands, runs
// screen clears with an internal raster scan and hands circles to the engine over start/done.
module circle_scheduler #(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [2:0] cmd_colour,
  input  logic [7:0] cmd_centre_x,
  input  logic [6:0] cmd_centre_y,
  input  logic [7:0] cmd_radius,
  output logic       eng_start,
  input  logic       eng_done,
  output logic [2:0] eng_colour,
  output logic [7:0] eng_centre_x,
  output logic [6:0] eng_centre_y,
  output logic [7:0] eng_radius,
  input  logic [7:0] eng_vga_x,
  input  logic [6:0] eng_vga_y,
  input  logic [2:0] eng_vga_colour,
  input  logic       eng_vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] jobs_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CLEAR   = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef struct packed {
    logic       clear;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  cmd_t          head;

  logic [1:0]    state;
  logic [2:0]    job_colour;
  logic [7:0]    job_centre_x;
  logic [6:0]    job_centre_y;
  logic [7:0]    job_radius;
  logic [7:0]    scan_x;
  logic [6:0]    scan_y;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign head      = mem[rd_ptr];

  // FIFO storage: data only, pointers and occupancy carry the reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{clear: cmd_clear, colour: cmd_colour, centre_x: cmd_centre_x,
                       centre_y: cmd_centre_y, radius: cmd_radius};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job sequencing; the clear scan is column-major so y wraps before x advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      job_colour   <= '0;
      job_centre_x <= '0;
      job_centre_y <= '0;
      job_radius   <= '0;
      scan_x       <= '0;
      scan_y       <= '0;
      jobs_done    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            job_colour   <= head.colour;
            job_centre_x <= head.centre_x;
            job_centre_y <= head.centre_y;
            job_radius   <= head.radius;
            scan_x       <= '0;
            scan_y       <= '0;
            state        <= head.clear ? S_CLEAR : S_RUN;
          end
        end
        S_CLEAR: begin
          if (scan_y == Y_LAST) begin
            scan_y <= '0;
            if (scan_x == X_LAST) begin
              state     <= S_IDLE;
              jobs_done <= jobs_done + 1'b1;
            end else begin
              scan_x <= scan_x + 1'b1;
            end
          end else begin
            scan_y <= scan_y + 1'b1;
          end
        end
        S_RUN: begin
          if (eng_done) state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!eng_done) begin
            state     <= S_IDLE;
            jobs_done <= jobs_done + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign eng_start    = (state == S_RUN);
  assign eng_colour   = job_colour;
  assign eng_centre_x = job_centre_x;
  assign eng_centre_y = job_centre_y;
  assign eng_radius   = job_radius;
  assign busy         = (state != S_IDLE) || (count != '0);

  // Plot-port mux: the engine owns it only while RUN, so stray plots in RELEASE are dropped
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      S_CLEAR: begin
        vga_x      = scan_x;
        vga_y      = scan_y;
        vga_colour = job_colour;
        vga_plot   = 1'b1;
      end
      S_RUN: begin
        vga_x      = eng_vga_x;
        vga_y      = eng_vga_y;
        vga_colour = eng_vga_colour;
        vga_plot   = eng_vga_plot;
      end
      default: begin
        vga_plot = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_circle_scheduler.sv
// Directed bench for circle_scheduler: reset, full-screen clear, circle dispatch table,
// FIFO backpressure with a stalled engine, and reset in the middle of a clear.
module tb_circle_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [2:0] cmd_colour;
  logic [7:0] cmd_centre_x;
  logic [6:0] cmd_centre_y;
  logic [7:0] cmd_radius;
  logic       eng_start;
  logic       eng_done;
  logic [2:0] eng_colour;
  logic [7:0] eng_centre_x;
  logic [6:0] eng_centre_y;
  logic [7:0] eng_radius;
  logic [7:0] eng_vga_x;
  logic [6:0] eng_vga_y;
  logic [2:0] eng_vga_colour;
  logic       eng_vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] jobs_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  circle_scheduler #(.DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
    .cmd_colour(cmd_colour), .cmd_centre_x(cmd_centre_x), .cmd_centre_y(cmd_centre_y),
    .cmd_radius(cmd_radius),
    .eng_start(eng_start), .eng_done(eng_done), .eng_colour(eng_colour),
    .eng_centre_x(eng_centre_x), .eng_centre_y(eng_centre_y), .eng_radius(eng_radius),
    .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y), .eng_vga_colour(eng_vga_colour),
    .eng_vga_plot(eng_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .jobs_done(jobs_done)
  );

  // Engine model: finishes ENG_LAT+1 cycles after start unless held, then holds done until start drops
  localparam int ENG_LAT = 3;
  logic eng_hold;
  int   eng_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (!eng_start) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (!eng_done && !eng_hold) begin
      if (eng_cnt == ENG_LAT) eng_done <= 1'b1;
      else eng_cnt <= eng_cnt + 1;
    end
  end

  typedef struct {
    logic [2:0] colour;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] r;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
    logic [7:0] exp_x;
    logic [6:0] exp_y;
    logic [2:0] exp_c;
    logic       exp_p;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic clr, input logic [2:0] c, input logic [7:0] cx,
                          input logic [6:0] cy, input logic [7:0] r);
    cmd_valid    = 1'b1;
    cmd_clear    = clr;
    cmd_colour   = c;
    cmd_centre_x = cx;
    cmd_centre_y = cy;
    cmd_radius   = r;
    tick;
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick;
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int nplot;
    int colour_err;
    int n;
    logic prev_ready;

    vecs[0] = '{3'b010, 8'd80,  7'd60,  8'd40,  8'd81,  7'd20,  3'b010, 1'b1, 8'd81,  7'd20,  3'b010, 1'b1};
    vecs[1] = '{3'b111, 8'd0,   7'd0,   8'd0,   8'd0,   7'd0,   3'b111, 1'b0, 8'd0,   7'd0,   3'b111, 1'b0};
    vecs[2] = '{3'b100, 8'd255, 7'd127, 8'd200, 8'd159, 7'd119, 3'b100, 1'b1, 8'd159, 7'd119, 3'b100, 1'b1};
    vecs[3] = '{3'b011, 8'd20,  7'd100, 8'd5,   8'd22,  7'd97,  3'b011, 1'b1, 8'd22,  7'd97,  3'b011, 1'b1};

    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_clear      = 1'b0;
    cmd_colour     = '0;
    cmd_centre_x   = '0;
    cmd_centre_y   = '0;
    cmd_radius     = '0;
    eng_vga_x      = '0;
    eng_vga_y      = '0;
    eng_vga_colour = '0;
    eng_vga_plot   = 1'b0;
    eng_hold       = 1'b0;

    // Reset state
    tick;
    tick;
    rst_n = 1'b1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_vga_plot", 32'(vga_plot), 32'd0);
    check("rst_vga_xy", {17'd0, vga_x, vga_y}, 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);

    // Full-screen clear
    push_cmd(1'b1, 3'b001, 8'd0, 7'd0, 8'd0);
    check("clear_busy_queued", 32'(busy), 32'd1);
    check("clear_idle_plot", 32'(vga_plot), 32'd0);
    tick;
    nplot = 0;
    colour_err = 0;
    while (vga_plot && nplot < 20000) begin
      if (nplot == 0)     check("clear_first_xy", {17'd0, vga_x, vga_y}, {17'd0, 8'd0, 7'd0});
      if (nplot == 1)     check("clear_second_xy", {17'd0, vga_x, vga_y}, {17'd0, 8'd0, 7'd1});
      if (nplot == 120)   check("clear_121st_xy", {17'd0, vga_x, vga_y}, {17'd0, 8'd1, 7'd0});
      if (nplot == 19199) check("clear_last_xy", {17'd0, vga_x, vga_y}, {17'd0, 8'd159, 7'd119});
      if (vga_colour !== 3'b001) colour_err++;
      nplot++;
      tick;
    end
    check("clear_plot_cycles", nplot, 32'd19200);
    check("clear_colour_errs", colour_err, 32'd0);
    check("clear_end_plot", 32'(vga_plot), 32'd0);
    check("clear_end_busy", 32'(busy), 32'd0);
    check("clear_jobs_done", 32'(jobs_done), 32'd1);

    // Circle dispatch table
    for (int i = 0; i < 4; i++) begin
      eng_vga_x      = vecs[i].ex;
      eng_vga_y      = vecs[i].ey;
      eng_vga_colour = vecs[i].ec;
      eng_vga_plot   = vecs[i].ep;
      push_cmd(1'b0, vecs[i].colour, vecs[i].cx, vecs[i].cy, vecs[i].r);
      check("circ_idle_start", 32'(eng_start), 32'd0);
      tick;
      check("circ_start", 32'(eng_start), 32'd1);
      check("circ_eng_colour", 32'(eng_colour), 32'(vecs[i].colour));
      check("circ_eng_cx", 32'(eng_centre_x), 32'(vecs[i].cx));
      check("circ_eng_cy", 32'(eng_centre_y), 32'(vecs[i].cy));
      check("circ_eng_r", 32'(eng_radius), 32'(vecs[i].r));
      check("circ_vga_x", 32'(vga_x), 32'(vecs[i].exp_x));
      check("circ_vga_y", 32'(vga_y), 32'(vecs[i].exp_y));
      check("circ_vga_colour", 32'(vga_colour), 32'(vecs[i].exp_c));
      check("circ_vga_plot", 32'(vga_plot), 32'(vecs[i].exp_p));
      n = 0;
      while (!eng_done && n < 50) begin
        tick;
        n++;
      end
      check("circ_done_seen", 32'(eng_done), 32'd1);
      check("circ_start_with_done", 32'(eng_start), 32'd1);
      tick;
      check("release_start", 32'(eng_start), 32'd0);
      check("release_plot", 32'(vga_plot), 32'd0);
      check("release_xy", {17'd0, vga_x, vga_y}, 32'd0);
      check("release_eng_cx", 32'(eng_centre_x), 32'(vecs[i].cx));
      wait_idle(20, "circ_idle");
      check("circ_idle_plot", 32'(vga_plot), 32'd0);
      check("circ_jobs_done", 32'(jobs_done), 32'(2 + i));
    end
    eng_vga_plot = 1'b0;

    // Backpressure with a stalled engine
    eng_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cmd_valid    = 1'b1;
      cmd_clear    = 1'b0;
      cmd_colour   = 3'(k);
      cmd_centre_x = 8'(10 + k);
      cmd_centre_y = 7'(30 + k);
      cmd_radius   = 8'(k + 1);
      check("bp_ready_before_push", 32'(cmd_ready), 32'd1);
      tick;
    end
    check("bp_ready_full", 32'(cmd_ready), 32'd0);
    check("bp_running_first", 32'(eng_start), 32'd1);
    check("bp_first_cx", 32'(eng_centre_x), 32'd10);
    cmd_centre_x = 8'd15;
    cmd_centre_y = 7'd35;
    cmd_colour   = 3'd5;
    cmd_radius   = 8'd6;
    tick;
    tick;
    tick;
    check("bp_sixth_held", 32'(cmd_ready), 32'd0);
    check("bp_still_first", 32'(eng_centre_x), 32'd10);
    eng_hold = 1'b0;
    n = 0;
    prev_ready = cmd_ready;
    while (!(eng_start && eng_centre_x == 8'd11) && n < 100) begin
      prev_ready = cmd_ready;
      tick;
      n++;
    end
    check("bp_second_popped", 32'(eng_centre_x), 32'd11);
    check("bp_ready_before_pop", 32'(prev_ready), 32'd0);
    check("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
    wait_idle(500, "bp_drain_idle");
    check("bp_jobs_done", 32'(jobs_done), 32'd11);
    check("bp_last_cx", 32'(eng_centre_x), 32'd15);

    // Reset in the middle of a clear with two circles queued
    push_cmd(1'b1, 3'b101, 8'd0, 7'd0, 8'd0);
    push_cmd(1'b0, 3'b010, 8'd40, 7'd40, 8'd10);
    push_cmd(1'b0, 3'b011, 8'd50, 7'd50, 8'd12);
    n = 0;
    while (!(vga_plot && vga_x == 8'd10 && vga_y == 7'd20) && n < 3000) begin
      tick;
      n++;
    end
    check("mid_clear_reached", {17'd0, vga_x, vga_y}, {17'd0, 8'd10, 7'd20});
    check("mid_clear_colour", 32'(vga_colour), 32'd5);
    rst_n = 1'b0;
    tick;
    check("midrst_plot", 32'(vga_plot), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_jobs_done", 32'(jobs_done), 32'd0);
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_plot", 32'(vga_plot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
